// File: rtl/uart_tx_piso_if.sv
// Word handshake between a producer and the UART transmit serializer.
interface uart_tx_piso_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_tx_piso.sv
// Parallel-in/serial-out shifter for the UART transmit path with a one-word
// holding register, so back-to-back words leave the line without a gap.
module uart_tx_piso #(
    parameter int   DATA_WIDTH = 8,
    parameter int   LSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = 1'b0,
    parameter int   CNT_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_piso_if.slave      s_if,
    input  logic               i_shift_en,
    input  logic               i_flush,
    output logic               o_s_output,
    output logic [CNT_W-1:0]   o_bit_no,
    output logic               o_busy,
    output logic               o_ser_done
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_LAST = 2'd2} state_t;

    localparam logic [CNT_W-1:0] LP_DW = CNT_W'(DATA_WIDTH);

    state_t                r_state,  w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pend,   w_pend_nxt;
    logic                  r_pend_v, w_pend_v_nxt;
    logic [DATA_WIDTH-1:0] r_shreg,  w_shreg_nxt;
    logic                  r_out,    w_out_nxt;
    logic [CNT_W-1:0]      r_bit_no, w_bit_no_nxt;
    logic                  r_done,   w_done_nxt;
    logic                  w_accept;
    logic [CNT_W-1:0]      w_bit_inc;

    // Bit driven when idx bits of the word have already gone out.
    function automatic logic pick_bit(input logic [DATA_WIDTH-1:0] word,
                                      input logic [CNT_W-1:0] idx);
        logic b;
        int   pos;
        b   = 1'b0;
        pos = (LSB_FIRST != 0) ? int'(idx) : (DATA_WIDTH - 1 - int'(idx));
        for (int i = 0; i < DATA_WIDTH; i++) begin
            b = (i == pos) ? word[i] : b;
        end
        return b;
    endfunction

    assign w_accept  = s_if.s_valid & ~r_pend_v;
    assign w_bit_inc = r_bit_no + CNT_W'(1);

    // Next-state and next-output logic for the serializer FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_pend_nxt   = r_pend;
        w_pend_v_nxt = r_pend_v;
        w_shreg_nxt  = r_shreg;
        w_out_nxt    = r_out;
        w_bit_no_nxt = r_bit_no;
        w_done_nxt   = 1'b0;
        if (i_flush) begin
            w_state_nxt  = ST_IDLE;
            w_pend_v_nxt = 1'b0;
            w_bit_no_nxt = '0;
            w_out_nxt    = IDLE_LEVEL;
        end else begin
            if (w_accept) begin
                w_pend_nxt   = s_if.s_data;
                w_pend_v_nxt = 1'b1;
            end else begin
                w_pend_nxt   = r_pend;
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_pend_v) begin
                        w_shreg_nxt  = r_pend;
                        w_pend_v_nxt = 1'b0;
                        w_bit_no_nxt = '0;
                        w_state_nxt  = ST_SHIFT;
                    end else begin
                        w_state_nxt  = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (i_shift_en) begin
                        w_out_nxt    = pick_bit(r_shreg, r_bit_no);
                        w_bit_no_nxt = w_bit_inc;
                        w_state_nxt  = (w_bit_inc == LP_DW) ? ST_LAST : ST_SHIFT;
                    end else begin
                        w_state_nxt  = ST_SHIFT;
                    end
                end
                ST_LAST: begin
                    if (i_shift_en) begin
                        w_done_nxt = 1'b1;
                        // Chain straight into the pending word to keep the line gapless.
                        if (r_pend_v) begin
                            w_shreg_nxt  = r_pend;
                            w_out_nxt    = pick_bit(r_pend, CNT_W'(0));
                            w_bit_no_nxt = CNT_W'(1);
                            w_pend_v_nxt = 1'b0;
                            w_state_nxt  = (DATA_WIDTH == 1) ? ST_LAST : ST_SHIFT;
                        end else begin
                            w_out_nxt    = IDLE_LEVEL;
                            w_bit_no_nxt = '0;
                            w_state_nxt  = ST_IDLE;
                        end
                    end else begin
                        w_state_nxt = ST_LAST;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_shreg  <= '0;
            r_out    <= IDLE_LEVEL;
            r_bit_no <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pend   <= w_pend_nxt;
            r_pend_v <= w_pend_v_nxt;
            r_shreg  <= w_shreg_nxt;
            r_out    <= w_out_nxt;
            r_bit_no <= w_bit_no_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign s_if.s_ready = ~r_pend_v;
    assign o_s_output   = r_out;
    assign o_bit_no     = r_bit_no;
    assign o_busy       = (r_state != ST_IDLE) | r_pend_v;
    assign o_ser_done   = r_done;
endmodule

// File: doc/uart_tx_piso.md
# uart_tx_piso

Parametrised parallel-in/serial-out shifter for the UART transmit path, successor to the fixed 8-bit serializer. It accepts words of DATA_WIDTH bits through a valid/ready handshake into a one-entry holding register, then shifts them out one bit per `shift_en` tick (baud strobe) in LSB-first or MSB-first order. Back-to-back words stream gaplessly, and the block reports the current bit index, busy status and an end-of-word pulse to the frame controller.

## Interface
- `DATA_WIDTH`, 8: word width in bits, 1..32.
- `LSB_FIRST`, 1: 1 = bit 0 first, 0 = bit DATA_WIDTH-1 first.
- `IDLE_LEVEL`, 1'b0: `s_output` level when not shifting.
- `CNT_W`, $clog2(DATA_WIDTH+1): width of `bit_no`. Derived; do not override.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  producer has a word on `s_data`.
- `s_data`  in  DATA_WIDTH  word to serialize.
- `s_ready`  out  1  holding register empty; a word is accepted when `s_valid & s_ready`.
- `shift_en`  in  1  one-cycle bit-period strobe.
- `flush`  in  1  synchronous abort.
- `s_output`  out  1  serial data, registered.
- `bit_no`  out  CNT_W  number of bits of the current word already driven, 0..DATA_WIDTH.
- `busy`  out  1  state != IDLE or holding register valid.
- `ser_done`  out  1  one-cycle pulse after the final bit period of a word.

## Operation
- Reset values: `s_output`=IDLE_LEVEL, `bit_no`=0, `s_ready`=1, `busy`=0, `ser_done`=0, state IDLE, holding register empty, shift register 0.
- Holding register (`pend`, `pend_v`):
  - On an accept, `pend`<=`s_data` and `pend_v`<=1.
  - `s_ready` = !`pend_v`, registered-derived.
  - `s_valid` while `s_ready`=0 is ignored. The producer holds its data until accepted.
- IDLE:
  - `s_output`=IDLE_LEVEL.
  - If `pend_v`: shift register <= `pend`, `pend_v`<=0, `bit_no`<=0, go to SHIFT. This needs no `shift_en`.
- SHIFT, on a `shift_en` with `bit_no`=k:
  - `s_output`<=bit k (LSB_FIRST) or bit DATA_WIDTH-1-k.
  - `bit_no`<=k+1.
  - If k+1 == DATA_WIDTH, go to LAST; otherwise stay in SHIFT.
- LAST (the final bit is on the line), on a `shift_en`:
  - `ser_done`<=1 for one cycle.
  - If `pend_v`: load `pend`, drive its first bit on `s_output` in the same cycle, `bit_no`<=1, `pend_v`<=0, next state is LAST if DATA_WIDTH==1, else SHIFT.
  - Otherwise: `s_output`<=IDLE_LEVEL, `bit_no`<=0, go to IDLE.
- `shift_en` in IDLE has no effect.
- `flush`, which has priority over everything except reset:
  - State goes to IDLE, `pend_v`<=0, `bit_no`<=0, `s_output`<=IDLE_LEVEL.
  - No `ser_done` is generated.
  - An accept in the same cycle is discarded.
- Simultaneous accept and drain:
  - An accept cannot coincide with a drain of `pend`, because `s_ready` is low whenever `pend_v`=1.
  - An accept in the cycle IDLE sees `pend_v`=0 lands in `pend` and is loaded on the next cycle.
- Reset mid-word: all state is lost immediately (asynchronous), and outputs return to reset values.
- `bit_no` never exceeds DATA_WIDTH and never wraps.

## Timing
- Accept to shift-register load: 1 clk in IDLE. The first bit appears at the first `shift_en` after the load.
- `s_output` and `bit_no` change only on `shift_en` cycles, flush, or reset. Each bit is held for exactly one `shift_en` period.
- `ser_done` is high in the clk immediately after the `shift_en` that ends the last bit period.
- With `pend_v` set before the final `shift_en`, consecutive words have zero idle bit periods between them.
- `s_ready` rises 1 clk after `pend` is drained.
- `shift_en` on consecutive clocks (a tick every cycle) is legal: one bit per clk.
- No combinational path from inputs to any output.

## Test plan
- Reset, then LSB_FIRST=1, DATA_WIDTH=8: accept 0xA5 with `shift_en` every 4 clk. Required: `s_output` = 1,0,1,0,0,1,0,1; `bit_no` steps 1..8; one `ser_done`; then `s_output`=0, `busy`=0.
- LSB_FIRST=0: send 0x1E. Required: `s_output` = 0,0,0,1,1,1,1,0.
- Accept 0xFF, then 0x00 while the first is still shifting. Required: `s_ready` low until 0x00 is drained; 16 contiguous bit periods with no IDLE_LEVEL gap; two `ser_done` pulses.
- `flush` asserted after 3 bits of 0x5A with a word pending. Required: next clk `s_output`=IDLE_LEVEL, `bit_no`=0, `s_ready`=1, `busy`=0; no `ser_done`.
- DATA_WIDTH=1, IDLE_LEVEL=1: stream 1,0,1 back-to-back with `shift_en` every clk. Required: `s_output` = 1,0,1, then 1 (idle); `ser_done` on each word; `bit_no` toggles 1 and 0.
- `rst` pulsed low during bit 4 of 0xC3. Required: outputs take their reset values asynchronously. After release, an accept of 0x81 serializes correctly from bit 0.
